// File: rtl/ex_operand_stage.sv
// ID/EX register with MEM/WB operand forwarding and load-use bubble insertion; 1-cycle latency.
// Backpressure: holds its contents while ex_ready=0, and drops id_ready on a load-use hazard or while holding.
module ex_operand_stage #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [4:0]             id_rd,
  input  logic                   id_use_rs2,
  input  logic [XLEN-1:0]        id_rs1_data,
  input  logic [XLEN-1:0]        id_rs2_data,
  input  logic [XLEN-1:0]        id_imm,
  input  logic                   id_alusrc,
  input  logic [2:0]             id_alucontrol,
  input  logic                   id_regwrite,
  input  logic                   id_memread,
  input  logic                   id_memwrite,
  input  logic                   ex_ready,
  input  logic                   flush,
  input  logic                   mem_regwrite,
  input  logic                   wb_regwrite,
  input  logic [4:0]             mem_rd,
  input  logic [4:0]             wb_rd,
  input  logic [XLEN-1:0]        mem_result,
  input  logic [XLEN-1:0]        wb_result,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        alu_a,
  output logic [XLEN-1:0]        alu_b,
  output logic [2:0]             alucontrol,
  output logic [XLEN-1:0]        ex_store_data,
  output logic [4:0]             ex_rd,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [2:0]      alucontrol;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
  } ex_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  ex_t                    ex_q;
  ex_t                    id_ins;
  logic                   valid_q;
  logic [STALL_CNT_W-1:0] stall_q;
  logic                   advance;
  logic                   load_use;
  logic [XLEN-1:0]        fwd_rs1;
  logic [XLEN-1:0]        fwd_rs2;

  assign id_ins = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                    rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
                    alusrc: id_alusrc, alucontrol: id_alucontrol,
                    regwrite: id_regwrite, memread: id_memread, memwrite: id_memwrite};

  assign advance  = !valid_q || ex_ready;
  assign load_use = valid_q && ex_q.memread && (ex_q.rd != 5'd0) &&
                    ((ex_q.rd == id_rs1) || (id_use_rs2 && (ex_q.rd == id_rs2)));
  assign id_ready = flush || (advance && !load_use);

  // x0 is never forwarded; MEM is younger than WB so it wins.
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    fwd_rs2 = ex_q.rs2_data;
    if (ex_q.rs1 != 5'd0) begin
      if (mem_regwrite && (mem_rd == ex_q.rs1))     fwd_rs1 = mem_result;
      else if (wb_regwrite && (wb_rd == ex_q.rs1))  fwd_rs1 = wb_result;
    end
    if (ex_q.rs2 != 5'd0) begin
      if (mem_regwrite && (mem_rd == ex_q.rs2))     fwd_rs2 = mem_result;
      else if (wb_regwrite && (wb_rd == ex_q.rs2))  fwd_rs2 = wb_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
      stall_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (advance && id_valid && !load_use) begin
      valid_q <= 1'b1;
      ex_q    <= id_ins;
    end else if (advance) begin
      valid_q <= 1'b0;
      if (load_use && id_valid && (stall_q != {STALL_CNT_W{1'b1}}))
        stall_q <= stall_q + STALL_ONE;
    end else begin
      // Holding: latch forwarded values so a result retiring from WB is not lost.
      ex_q.rs1_data <= fwd_rs1;
      ex_q.rs2_data <= fwd_rs2;
    end
  end

  assign ex_valid      = valid_q;
  assign alu_a         = valid_q ? fwd_rs1 : '0;
  assign alu_b         = valid_q ? (ex_q.alusrc ? ex_q.imm : fwd_rs2) : '0;
  assign ex_store_data = valid_q ? fwd_rs2 : '0;
  assign alucontrol    = valid_q ? ex_q.alucontrol : 3'd0;
  assign ex_rd         = valid_q ? ex_q.rd : 5'd0;
  assign ex_regwrite   = valid_q && ex_q.regwrite;
  assign ex_memread    = valid_q && ex_q.memread;
  assign ex_memwrite   = valid_q && ex_q.memwrite;
  assign stall_count   = stall_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: per-cycle model comparison plus literal spot checks.
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  localparam int SW   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic id_valid = 0, id_use_rs2 = 0, id_alusrc = 0;
  logic id_regwrite = 0, id_memread = 0, id_memwrite = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic [2:0] id_alucontrol = 0;
  logic ex_ready = 1, flush = 0, mem_regwrite = 0, wb_regwrite = 0;
  logic [4:0] mem_rd = 0, wb_rd = 0;
  logic [31:0] mem_result = 0, wb_result = 0;
  logic id_ready, ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0] alucontrol;
  logic [4:0] ex_rd;
  logic [SW-1:0] stall_count;

  ex_operand_stage #(.XLEN(XLEN), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alusrc(id_alusrc), .id_alucontrol(id_alucontrol), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .ex_ready(ex_ready),
    .flush(flush), .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_result(mem_result), .wb_result(wb_result),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alucontrol(alucontrol),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .stall_count(stall_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an optional instruction record sitting in EX.
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        alusrc;
    logic [2:0]  ctl;
    logic        rw, mr, mw;
  } instr_t;

  instr_t m_ins;
  bit     m_live = 0;
  int     m_stalls = 0;

  function automatic logic [31:0] m_src(input logic [4:0] r, input logic [31:0] kept);
    if (r == 5'd0) return kept;
    if (mem_regwrite && mem_rd == r) return mem_result;
    if (wb_regwrite && wb_rd == r) return wb_result;
    return kept;
  endfunction

  function automatic bit m_hazard();
    return m_live && m_ins.mr && m_ins.rd != 5'd0 &&
           (m_ins.rd == id_rs1 || (id_use_rs2 && m_ins.rd == id_rs2));
  endfunction

  function automatic bit m_stuck();
    return m_live && !ex_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_live   = 0;
      m_ins    = '{default: 0};
      m_stalls = 0;
    end else if (flush) begin
      m_live = 0;
    end else if (m_stuck()) begin
      m_ins.d1 = m_src(m_ins.rs1, m_ins.d1);
      m_ins.d2 = m_src(m_ins.rs2, m_ins.d2);
    end else if (id_valid && !m_hazard()) begin
      m_live = 1;
      m_ins  = '{rs1: id_rs1, rs2: id_rs2, rd: id_rd, d1: id_rs1_data, d2: id_rs2_data,
                 imm: id_imm, alusrc: id_alusrc, ctl: id_alucontrol,
                 rw: id_regwrite, mr: id_memread, mw: id_memwrite};
    end else begin
      if (id_valid && m_hazard() && m_stalls < (1 << SW) - 1) m_stalls++;
      m_live = 0;
    end
  end

  always @(negedge clk) begin
    logic [31:0] ea, eb, es;
    ea = 0; eb = 0; es = 0;
    if (m_live) begin
      ea = m_src(m_ins.rs1, m_ins.d1);
      es = m_src(m_ins.rs2, m_ins.d2);
      eb = m_ins.alusrc ? m_ins.imm : es;
    end
    check("id_ready", {31'd0, id_ready}, {31'd0, flush || (!m_stuck() && !m_hazard())});
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m_live});
    check("alu_a", alu_a, ea);
    check("alu_b", alu_b, eb);
    check("ex_store_data", ex_store_data, es);
    check("alucontrol", {29'd0, alucontrol}, m_live ? {29'd0, m_ins.ctl} : 32'd0);
    check("ex_rd", {27'd0, ex_rd}, m_live ? {27'd0, m_ins.rd} : 32'd0);
    check("ex_ctl", {29'd0, ex_regwrite, ex_memread, ex_memwrite},
          m_live ? {29'd0, m_ins.rw, m_ins.mr, m_ins.mw} : 32'd0);
    check("stall_count", {16'd0, stall_count}, m_stalls);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_use_rs2 = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alusrc = 0; id_alucontrol = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic offer(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic use2, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic src, input logic [2:0] ctl,
                       input logic rw, input logic mr, input logic mw);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_use_rs2 = use2;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alusrc = src;
    id_alucontrol = ctl; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
  endtask

  initial begin
    quiet();
    repeat (2) tick();
    #3;
    check("rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("rst stall_count", {16'd0, stall_count}, 32'd0);
    check("rst alu_a", alu_a, 32'd0);
    check("rst id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    rst_n = 1;

    // Back-to-back independent: add x3=x1+x2, then or x4=x5|x6
    offer(5'd1, 5'd2, 5'd3, 1, 32'd5, 32'd7, 32'd0, 0, 3'b000, 1, 0, 0);
    #3 check("t1 id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    offer(5'd5, 5'd6, 5'd4, 1, 32'hA, 32'h3, 32'd0, 0, 3'b011, 1, 0, 0);
    #3;
    check("t1 add alu_a", alu_a, 32'd5);
    check("t1 add alu_b", alu_b, 32'd7);
    check("t1 add ctl", {29'd0, alucontrol}, 32'd0);
    check("t1 id_ready2", {31'd0, id_ready}, 32'd1);
    tick();
    offer(5'd3, 5'd2, 5'd8, 1, 32'd1, 32'd2, 32'd0, 0, 3'b001, 1, 0, 0);
    #3 check("t1 or ctl", {29'd0, alucontrol}, 32'd3);

    // MEM has priority over WB
    tick();
    quiet();
    mem_regwrite = 1; mem_rd = 5'd3; mem_result = 32'h10;
    wb_regwrite = 1; wb_rd = 5'd3; wb_result = 32'h20;
    #3;
    check("t2 alu_a mem prio", alu_a, 32'h10);
    check("t2 ctl sub", {29'd0, alucontrol}, 32'd1);
    check("t2 alu_b", alu_b, 32'd2);

    // x0 is never forwarded
    quiet();
    offer(5'd0, 5'd0, 5'd9, 1, 32'd0, 32'd0, 32'h44, 1, 3'b000, 1, 0, 0);
    tick();
    quiet();
    mem_regwrite = 1; mem_rd = 5'd0; mem_result = 32'hFFFF;
    wb_regwrite = 1; wb_rd = 5'd0; wb_result = 32'h1234;
    #3;
    check("t3 x0 alu_a", alu_a, 32'd0);
    check("t3 imm alu_b", alu_b, 32'h44);
    check("t3 x0 store", ex_store_data, 32'd0);

    // Load-use: lw x5,4(x1) then add x6=x5+x1
    quiet();
    offer(5'd1, 5'd0, 5'd5, 0, 32'h100, 32'd0, 32'd4, 1, 3'b000, 1, 1, 0);
    tick();
    offer(5'd5, 5'd1, 5'd6, 1, 32'd0, 32'h100, 32'd0, 0, 3'b000, 1, 0, 0);
    #3;
    check("t4 lu id_ready", {31'd0, id_ready}, 32'd0);
    check("t4 lw alu_a", alu_a, 32'h100);
    check("t4 lw alu_b", alu_b, 32'd4);
    tick();
    mem_regwrite = 1; mem_rd = 5'd5; mem_result = 32'hABCD;
    #3;
    check("t4 bubble", {31'd0, ex_valid}, 32'd0);
    check("t4 stall_count", {16'd0, stall_count}, 32'd1);
    check("t4 id_ready after", {31'd0, id_ready}, 32'd1);
    tick();
    quiet();
    wb_regwrite = 1; wb_rd = 5'd5; wb_result = 32'hABCD;
    #3;
    check("t4 add valid", {31'd0, ex_valid}, 32'd1);
    check("t4 add fwd alu_a", alu_a, 32'hABCD);
    check("t4 add alu_b", alu_b, 32'h100);
    check("t4 stall hold", {16'd0, stall_count}, 32'd1);

    // Downstream stall with WB refresh of rs2
    tick();
    quiet();
    offer(5'd8, 5'd9, 5'd7, 1, 32'hF0, 32'h11, 32'd0, 0, 3'b010, 1, 0, 0);
    tick();
    offer(5'd1, 5'd2, 5'd10, 1, 32'd1, 32'd2, 32'd0, 0, 3'b100, 1, 0, 0);
    ex_ready = 0;
    #3;
    check("t5 id_ready hold0", {31'd0, id_ready}, 32'd0);
    check("t5 alu_b pre", alu_b, 32'h11);
    tick();
    wb_regwrite = 1; wb_rd = 5'd9; wb_result = 32'h99;
    #3;
    check("t5 id_ready hold1", {31'd0, id_ready}, 32'd0);
    check("t5 alu_b wb fwd", alu_b, 32'h99);
    tick();
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
    #3;
    check("t5 id_ready hold2", {31'd0, id_ready}, 32'd0);
    check("t5 alu_b refreshed", alu_b, 32'h99);
    tick();
    ex_ready = 1;
    #3;
    check("t5 alu_b release", alu_b, 32'h99);
    check("t5 alu_a release", alu_a, 32'hF0);
    check("t5 ctl and", {29'd0, alucontrol}, 32'd2);
    check("t5 id_ready release", {31'd0, id_ready}, 32'd1);
    tick();
    quiet();
    #3;
    check("t5 xor ctl", {29'd0, alucontrol}, 32'd4);
    check("t5 xor alu_a", alu_a, 32'd1);

    // Flush beats load-use; no stall counted
    tick();
    offer(5'd1, 5'd0, 5'd5, 0, 32'h200, 32'd0, 32'd8, 1, 3'b000, 1, 1, 0);
    tick();
    offer(5'd5, 5'd0, 5'd6, 0, 32'd0, 32'd0, 32'd0, 0, 3'b000, 1, 0, 0);
    #1 check("t6 lu id_ready", {31'd0, id_ready}, 32'd0);
    flush = 1;
    #2 check("t6 flush id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    quiet();
    #3;
    check("t6 flushed", {31'd0, ex_valid}, 32'd0);
    check("t6 stall unchanged", {16'd0, stall_count}, 32'd1);

    // Flush while downstream stalled
    offer(5'd1, 5'd2, 5'd3, 1, 32'd4, 32'd4, 32'd0, 0, 3'b000, 1, 0, 0);
    tick();
    quiet();
    ex_ready = 0; flush = 1;
    tick();
    quiet();
    #3 check("t7 flush stalled", {31'd0, ex_valid}, 32'd0);

    // Async reset mid-stall
    offer(5'd1, 5'd0, 5'd5, 0, 32'h300, 32'd0, 32'd4, 1, 3'b000, 1, 1, 0);
    tick();
    offer(5'd5, 5'd0, 5'd6, 0, 32'd0, 32'd0, 32'd0, 0, 3'b000, 1, 0, 0);
    ex_ready = 0;
    #2 rst_n = 0;
    #1;
    check("t8 rst ex_valid", {31'd0, ex_valid}, 32'd0);
    check("t8 rst alu_b", alu_b, 32'd0);
    check("t8 rst memread", {31'd0, ex_memread}, 32'd0);
    check("t8 rst stall_count", {16'd0, stall_count}, 32'd0);
    tick();
    quiet();
    tick();
    rst_n = 1;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
